inst_fetch: RTL and testbench

Multicycle MIPS32 instruction fetch unit, the producer side of the instruction-register load interface. It owns the PC and runs a req/ack read to instruction memory. It delivers the fetched word on DataOut with a single-cycle IR_W strobe to the instruction register. Started by the control FSM at the start of each instruction; redirected by branch/jump logic via pc_load.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/inst_fetch.sv | 144 ++++++++++++++
 tb/tb_inst_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: fetch FSM encoding, reset PC and instruction field widths.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int JADDR_W  = 26;

endpackage

// File: rtl/inst_fetch.sv
// Multicycle MIPS32 instruction fetch: owns the PC, runs a req/ack read and strobes IR_W for one cycle.
// Latency: IR_W rises the cycle after the ack edge (2 cycles after fetch_start with zero wait states).
module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] DataOut,
    output logic        IR_W,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        fetch_err
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  mem_addr_q;
    logic         mem_rd_q;
    logic [31:0]  data_q;
    logic         ir_w_q;
    logic         busy_q;
    logic         err_q;
    logic [7:0]   wait_cnt_q;
    logic         pend_vld_q;
    logic [31:0]  pend_pc_q;

    logic [31:0]  fetch_addr_d;
    logic [31:0]  pc_plus4_d;

    assign pc_plus4_d   = pc_q + 32'd4;
    assign fetch_addr_d = pc_load ? pc_next : pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_rd_q   <= 1'b0;
            data_q     <= 32'd0;
            ir_w_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            wait_cnt_q <= 8'd0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ir_w_q <= 1'b0;
                    if (fetch_start) begin
                        pc_q <= fetch_addr_d;
                        if (fetch_addr_d[1:0] != 2'b00) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q    <= ST_REQ;
                            mem_addr_q <= fetch_addr_d;
                            mem_rd_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            wait_cnt_q <= 8'd0;
                        end
                    end else if (pc_load) begin
                        pc_q <= pc_next;
                    end
                end

                ST_REQ: begin
                    if (pc_load) begin
                        pend_vld_q <= 1'b1;
                        pend_pc_q  <= pc_next;
                    end
                    if (mem_ack) begin
                        // A redirect arriving on the ack edge itself is the newest one.
                        data_q     <= mem_rdata;
                        mem_rd_q   <= 1'b0;
                        ir_w_q     <= 1'b1;
                        state_q    <= ST_DONE;
                        pend_vld_q <= 1'b0;
                        if (pc_load)
                            pc_q <= pc_next;
                        else if (pend_vld_q)
                            pc_q <= pend_pc_q;
                        else
                            pc_q <= pc_plus4_d;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= ST_ERR;
                        err_q      <= 1'b1;
                        mem_rd_q   <= 1'b0;
                        busy_q     <= 1'b0;
                        pend_vld_q <= 1'b0;
                    end else if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                ST_DONE: begin
                    ir_w_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                    pend_vld_q <= 1'b0;
                    if (pc_load)
                        pc_q <= pc_next;
                    else if (pend_vld_q)
                        pc_q <= pend_pc_q;
                end

                ST_ERR: begin
                    ir_w_q   <= 1'b0;
                    mem_rd_q <= 1'b0;
                    if (pc_load) begin
                        pc_q    <= pc_next;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign DataOut   = data_q;
    assign IR_W      = ir_w_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_plus4_d;
    assign busy      = busy_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed-vector bench for inst_fetch with hand-computed expectations.
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic        fetch_start;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] DataOut;
    logic        IR_W;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;
    int irw_cnt  = 0;
    int irw_base;

    inst_fetch #(.RESET_PC(32'h0040_0000), .MAX_WAIT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_start(fetch_start),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .DataOut    (DataOut),
        .IR_W       (IR_W),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (IR_W === 1'b1) irw_cnt <= irw_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_start = 1'b0; pc_load = 1'b0; pc_next = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_addr", mem_addr, 32'h0040_0000);
        chk("rst_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_irw", {31'd0, IR_W}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_data", DataOut, 32'd0);
        chk("rst_p4", pc_plus4, 32'h0040_0004);
        rst_n = 1'b1;
        step();

        // Fetch with two wait states
        irw_base = irw_cnt;
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        chk("f1_rd", {31'd0, mem_rd}, 32'd1);
        chk("f1_addr", mem_addr, 32'h0040_0000);
        chk("f1_busy", {31'd0, busy}, 32'd1);
        step(); step();
        chk("f1_rd_wait", {31'd0, mem_rd}, 32'd1);
        chk("f1_irw_wait", {31'd0, IR_W}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h8C22_0004; step(); mem_ack = 1'b0; mem_rdata = '0;
        chk("f1_irw", {31'd0, IR_W}, 32'd1);
        chk("f1_data", DataOut, 32'h8C22_0004);
        chk("f1_pc", pc, 32'h0040_0004);
        chk("f1_rd_off", {31'd0, mem_rd}, 32'd0);
        step();
        chk("f1_irw_off", {31'd0, IR_W}, 32'd0);
        chk("f1_hold", DataOut, 32'h8C22_0004);
        chk("f1_idle", {31'd0, busy}, 32'd0);
        step();
        chk("f1_pulses", irw_cnt - irw_base, 32'd1);

        // Redirect together with fetch_start, zero-wait ack
        pc_load = 1'b1; pc_next = 32'h0040_0100; fetch_start = 1'b1; step();
        pc_load = 1'b0; fetch_start = 1'b0;
        chk("f2_addr", mem_addr, 32'h0040_0100);
        mem_ack = 1'b1; mem_rdata = 32'h2108_0001; step(); mem_ack = 1'b0;
        chk("f2_irw", {31'd0, IR_W}, 32'd1);
        chk("f2_data", DataOut, 32'h2108_0001);
        step();
        chk("f2_pc", pc, 32'h0040_0104);

        // Redirect while in REQ overrides +4
        irw_base = irw_cnt;
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        chk("f3_addr", mem_addr, 32'h0040_0104);
        pc_load = 1'b1; pc_next = 32'h0040_0040; step(); pc_load = 1'b0;
        step(); step();
        chk("f3_pc_hold", pc, 32'h0040_0104);
        mem_ack = 1'b1; mem_rdata = 32'h0800_0010; step(); mem_ack = 1'b0;
        chk("f3_pc", pc, 32'h0040_0040);
        chk("f3_irw", {31'd0, IR_W}, 32'd1);
        step(); step();
        chk("f3_pulses", irw_cnt - irw_base, 32'd1);
        chk("f3_pc_after", pc, 32'h0040_0040);

        // Timeout: mem_rd high for exactly 16 cycles
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        for (int i = 0; i < 15; i++) step();
        chk("to_rd_15", {31'd0, mem_rd}, 32'd1);
        chk("to_err_15", {31'd0, fetch_err}, 32'd0);
        step();
        chk("to_rd_16", {31'd0, mem_rd}, 32'd0);
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_pc", pc, 32'h0040_0040);
        fetch_start = 1'b1; step(); step(); fetch_start = 1'b0;
        chk("to_ign_rd", {31'd0, mem_rd}, 32'd0);
        chk("to_ign_err", {31'd0, fetch_err}, 32'd1);
        chk("to_ign_pc", pc, 32'h0040_0040);
        pc_load = 1'b1; pc_next = 32'h0040_0000; step(); pc_load = 1'b0;
        chk("to_clr_err", {31'd0, fetch_err}, 32'd0);
        chk("to_clr_pc", pc, 32'h0040_0000);

        // Misaligned fetch address
        pc_load = 1'b1; pc_next = 32'h0040_0203; fetch_start = 1'b1; step();
        pc_load = 1'b0; fetch_start = 1'b0;
        chk("mis_err", {31'd0, fetch_err}, 32'd1);
        chk("mis_rd", {31'd0, mem_rd}, 32'd0);
        step();
        chk("mis_rd2", {31'd0, mem_rd}, 32'd0);
        pc_load = 1'b1; pc_next = 32'hFFFF_FFFC; step(); pc_load = 1'b0;
        chk("mis_clr", {31'd0, fetch_err}, 32'd0);

        // PC wrap at top of address space
        chk("wrap_p4", pc_plus4, 32'h0000_0000);
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        mem_ack = 1'b1; step(); mem_ack = 1'b0;
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_err", {31'd0, fetch_err}, 32'd0);
        step();

        // Asynchronous reset in the middle of REQ
        fetch_start = 1'b1; step(); fetch_start = 1'b0;
        chk("ar_rd_pre", {31'd0, mem_rd}, 32'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_rd", {31'd0, mem_rd}, 32'd0);
        chk("ar_pc", pc, 32'h0040_0000);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
